// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar arbiter: FSM states, the
// captured A-channel payload, the memory map and the TileLink opcodes used.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    A_PHASE  = 2'd1,
    D_WAIT   = 2'd2,
    ERR_RESP = 2'd3
  } xbar_state_e;

  localparam int CHIP_NUM = 6;

  // Region order fixes the chip_sel bit: 0 ROM, 1 CLINT, 2 PLIC, 3 UART,
  // 4 FLASH, 5 RAM.
  localparam logic [63:0] REGION_BASE [CHIP_NUM] = '{
    64'h0000_0000_0000_1000,
    64'h0000_0000_0200_0000,
    64'h0000_0000_0C00_0000,
    64'h0000_0000_1000_0000,
    64'h0000_0000_2000_0000,
    64'h0000_0000_8000_0000
  };

  localparam logic [63:0] REGION_SIZE [CHIP_NUM] = '{
    64'h0000_0000_0000_1000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0400_0000,
    64'h0000_0000_0000_0100,
    64'h0000_0000_0200_0000,
    64'h0000_0000_8000_0000
  };

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  // Registered copy of the granted master's A beat.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [63:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_payload_t;

endpackage

// File: rtl/crossbar_arb_if.sv
// Bundle of all handshake/bus signals around the crossbar arbiter: NM master
// A/D channel pairs, the single downstream slave A/D pair and the decode
// outputs. The slave modport is the arbiter's view; master is the
// environment's view.
//
// Handshake rule on every channel: a beat transfers on a rising clk edge
// where valid && ready are both 1; the sender keeps valid and payload
// stable until that edge, and valid never depends on ready.
interface crossbar_arb_if #(parameter int NM = 2);
  import xbar_pkg::*;

  logic [NM-1:0][2:0]  m_a_opcode;
  logic [NM-1:0][2:0]  m_a_param;
  logic [NM-1:0][2:0]  m_a_size;
  logic [NM-1:0][3:0]  m_a_source;
  logic [NM-1:0][63:0] m_a_address;
  logic [NM-1:0][7:0]  m_a_mask;
  logic [NM-1:0][63:0] m_a_data;
  logic [NM-1:0]       m_a_corrupt;
  logic [NM-1:0]       m_a_valid;
  logic [NM-1:0]       m_a_ready;

  logic [2:0]          m_d_opcode;
  logic [3:0]          m_d_source;
  logic [63:0]         m_d_data;
  logic                m_d_denied;
  logic [NM-1:0]       m_d_valid;
  logic [NM-1:0]       m_d_ready;

  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [2:0]          a_size;
  logic [3:0]          a_source;
  logic [63:0]         a_address;
  logic [7:0]          a_mask;
  logic [63:0]         a_data;
  logic                a_corrupt;
  logic                a_valid;
  logic                a_ready;

  logic [CHIP_NUM-1:0] chip_sel;
  logic [63:0]         chip_addr;

  logic [2:0]          d_opcode;
  logic [3:0]          d_source;
  logic [63:0]         d_data;
  logic                d_denied;
  logic                d_valid;
  logic                d_ready;

  modport slave (
    input  m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
           m_a_mask, m_a_data, m_a_corrupt, m_a_valid,
    output m_a_ready,
    output m_d_opcode, m_d_source, m_d_data, m_d_denied, m_d_valid,
    input  m_d_ready,
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           a_corrupt, a_valid,
    input  a_ready,
    output chip_sel, chip_addr,
    input  d_opcode, d_source, d_data, d_denied, d_valid,
    output d_ready
  );

  modport master (
    output m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
           m_a_mask, m_a_data, m_a_corrupt, m_a_valid,
    input  m_a_ready,
    input  m_d_opcode, m_d_source, m_d_data, m_d_denied, m_d_valid,
    output m_d_ready,
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           a_corrupt, a_valid,
    output a_ready,
    input  chip_sel, chip_addr,
    output d_opcode, d_source, d_data, d_denied, d_valid,
    input  d_ready
  );

endinterface

// File: rtl/xbar_addr_decode.sv
// Combinational address decoder: finds the region with
// base <= addr < base + size and returns its one-hot select and offset.
// Misses return hit=0, chip_sel=0, chip_addr=0.
module xbar_addr_decode
  import xbar_pkg::*;
(
  input  logic [63:0]         addr,
  output logic                hit,
  output logic [CHIP_NUM-1:0] chip_sel,
  output logic [63:0]         chip_addr
);

  // Compare via (addr - base) < size so the RAM region ending at 2^32
  // needs no wider arithmetic.
  always_comb begin
    hit       = 1'b0;
    chip_sel  = '0;
    chip_addr = '0;
    for (int r = 0; r < CHIP_NUM; r++) begin
      if (!hit && (addr >= REGION_BASE[r]) &&
          ((addr - REGION_BASE[r]) < REGION_SIZE[r])) begin
        hit         = 1'b1;
        chip_sel[r] = 1'b1;
        chip_addr   = addr - REGION_BASE[r];
      end
    end
  end

endmodule

// File: rtl/crossbar_arb.sv
// NM-to-1 TileLink-style arbiter with one outstanding transaction. A
// round-robin winner's A beat is accepted in IDLE, registered with its
// decode, then forwarded (A_PHASE) and its D response routed back (D_WAIT).
// Unmapped addresses never reach the slave; ERR_RESP answers with denied.
module crossbar_arb
  import xbar_pkg::*;
#(
  parameter int NM = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  crossbar_arb_if.slave bus,
  output xbar_state_e  dbg_state
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  typedef logic [GW-1:0] gidx_t;

  xbar_state_e         state_q, state_d;
  gidx_t               grant_q, grant_d;
  gidx_t               last_grant_q, last_grant_d;
  a_payload_t          pay_q, pay_d;
  logic [CHIP_NUM-1:0] chip_sel_q, chip_sel_d;
  logic [63:0]         chip_addr_q, chip_addr_d;

  logic                req_found;
  gidx_t               req_idx;
  gidx_t               rr_cand;
  logic [63:0]         req_addr;

  logic                dec_hit;
  logic [CHIP_NUM-1:0] dec_sel;
  logic [63:0]         dec_off;

  logic [NM-1:0]       m_a_ready_c;
  logic [NM-1:0]       m_d_valid_c;
  logic [2:0]          m_d_opcode_c;
  logic [3:0]          m_d_source_c;
  logic [63:0]         m_d_data_c;
  logic                m_d_denied_c;
  logic                a_valid_c;
  logic                d_ready_c;

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    req_found = 1'b0;
    req_idx   = last_grant_q;
    rr_cand   = last_grant_q;
    for (int i = 1; i <= NM; i++) begin
      rr_cand = gidx_t'((int'(last_grant_q) + i) % NM);
      if (!req_found && bus.m_a_valid[rr_cand]) begin
        req_found = 1'b1;
        req_idx   = rr_cand;
      end
    end
  end

  assign req_addr = bus.m_a_address[req_idx];

  xbar_addr_decode u_decode (
    .addr      (req_addr),
    .hit       (dec_hit),
    .chip_sel  (dec_sel),
    .chip_addr (dec_off)
  );

  // Next-state, capture and per-state channel routing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pay_d        = pay_q;
    chip_sel_d   = chip_sel_q;
    chip_addr_d  = chip_addr_q;
    m_a_ready_c  = '0;
    m_d_valid_c  = '0;
    m_d_opcode_c = '0;
    m_d_source_c = '0;
    m_d_data_c   = '0;
    m_d_denied_c = 1'b0;
    a_valid_c    = 1'b0;
    d_ready_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          m_a_ready_c[req_idx] = 1'b1;
          grant_d     = req_idx;
          pay_d       = '{opcode:  bus.m_a_opcode[req_idx],
                          param:   bus.m_a_param[req_idx],
                          size:    bus.m_a_size[req_idx],
                          source:  bus.m_a_source[req_idx],
                          address: bus.m_a_address[req_idx],
                          mask:    bus.m_a_mask[req_idx],
                          data:    bus.m_a_data[req_idx],
                          corrupt: bus.m_a_corrupt[req_idx]};
          chip_sel_d  = dec_sel;
          chip_addr_d = dec_off;
          state_d     = dec_hit ? A_PHASE : ERR_RESP;
        end
      end
      A_PHASE: begin
        a_valid_c = 1'b1;
        if (bus.a_ready) state_d = D_WAIT;
      end
      D_WAIT: begin
        m_d_valid_c[grant_q] = bus.d_valid;
        d_ready_c    = bus.m_d_ready[grant_q];
        m_d_opcode_c = bus.d_opcode;
        m_d_source_c = bus.d_source;
        m_d_data_c   = bus.d_data;
        m_d_denied_c = bus.d_denied;
        if (bus.d_valid && bus.m_d_ready[grant_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      ERR_RESP: begin
        m_d_valid_c[grant_q] = 1'b1;
        m_d_denied_c = 1'b1;
        m_d_source_c = pay_q.source;
        m_d_opcode_c = (pay_q.opcode == OP_GET) ? OP_ACCESS_ACK_DATA
                                                 : OP_ACCESS_ACK;
        if (bus.m_d_ready[grant_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= gidx_t'(NM - 1);
      pay_q        <= '0;
      chip_sel_q   <= '0;
      chip_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pay_q        <= pay_d;
      chip_sel_q   <= chip_sel_d;
      chip_addr_q  <= chip_addr_d;
    end
  end

  assign bus.m_a_ready  = m_a_ready_c;
  assign bus.m_d_valid  = m_d_valid_c;
  assign bus.m_d_opcode = m_d_opcode_c;
  assign bus.m_d_source = m_d_source_c;
  assign bus.m_d_data   = m_d_data_c;
  assign bus.m_d_denied = m_d_denied_c;
  assign bus.d_ready    = d_ready_c;

  assign bus.a_valid    = a_valid_c;
  assign bus.a_opcode   = pay_q.opcode;
  assign bus.a_param    = pay_q.param;
  assign bus.a_size     = pay_q.size;
  assign bus.a_source   = pay_q.source;
  assign bus.a_address  = pay_q.address;
  assign bus.a_mask     = pay_q.mask;
  assign bus.a_data     = pay_q.data;
  assign bus.a_corrupt  = pay_q.corrupt;
  assign bus.chip_sel   = chip_sel_q;
  assign bus.chip_addr  = chip_addr_q;

  assign dbg_state      = state_q;

endmodule

// File: tb/tb_crossbar_arb.sv
// Directed bench for crossbar_arb: single Get, round-robin alternation,
// unmapped access, stalled UART access, decode boundaries and mid-transaction
// reset. Inputs change 1 time unit after posedge; outputs are sampled at
// negedge.
module tb_crossbar_arb;
  import xbar_pkg::*;

  logic        clk;
  logic        rst_n;
  xbar_state_e dbg_state;
  int          n_checks;
  int          n_errors;
  logic [7:0]  exp_q[$];

  crossbar_arb_if #(.NM(2)) bus ();

  crossbar_arb #(.NM(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int m, input logic [2:0] op,
                         input logic [3:0] src, input logic [63:0] addr);
    bus.m_a_opcode[m]  = op;
    bus.m_a_param[m]   = 3'd0;
    bus.m_a_size[m]    = 3'd3;
    bus.m_a_source[m]  = src;
    bus.m_a_address[m] = addr;
    bus.m_a_mask[m]    = 8'hff;
    bus.m_a_data[m]    = {32'hcafe_0000, 28'h0, src};
    bus.m_a_corrupt[m] = 1'b0;
    bus.m_a_valid[m]   = 1'b1;
  endtask

  task automatic clr_req(input int m);
    bus.m_a_valid[m] = 1'b0;
  endtask

  // One M0 Get through decode; slave answers at once (a_ready, d_valid held).
  task automatic probe(input logic [63:0] addr, input logic [5:0] esel,
                       input logic [63:0] eoff);
    cyc();
    set_req(0, OP_GET, 4'd1, addr);
    smp();
    check_eq("probe_grant", 64'(bus.m_a_ready), 64'h1);
    cyc();
    clr_req(0);
    smp();
    check_eq("probe_sel", 64'(bus.chip_sel), 64'(esel));
    check_eq("probe_off", bus.chip_addr, eoff);
    check_eq("probe_avalid", 64'(bus.a_valid), 64'(esel != 6'd0));
    if (esel == 6'd0) begin
      check_eq("probe_denied", 64'(bus.m_d_denied), 64'h1);
      check_eq("probe_err_op", 64'(bus.m_d_opcode), 64'(OP_ACCESS_ACK_DATA));
      check_eq("probe_err_data", bus.m_d_data, 64'h0);
    end else begin
      cyc();
      smp();
      check_eq("probe_dvalid", 64'(bus.m_d_valid), 64'h1);
    end
    cyc();
    smp();
    check_eq("probe_idle", 64'(dbg_state), 64'(IDLE));
  endtask

  localparam int NPROBE = 10;
  logic [63:0] pv_addr [NPROBE] = '{
    64'h0000_1000, 64'h0000_1FFF, 64'h0000_2000, 64'h0200_FFFF,
    64'h0C00_0004, 64'h2000_0100, 64'h1000_0100, 64'hFFFF_FFFF,
    64'h1_0000_0000, 64'h0
  };
  logic [5:0] pv_sel [NPROBE] = '{
    6'b000001, 6'b000001, 6'b000000, 6'b000010,
    6'b000100, 6'b010000, 6'b000000, 6'b100000,
    6'b000000, 6'b000000
  };
  logic [63:0] pv_off [NPROBE] = '{
    64'h0, 64'hFFF, 64'h0, 64'hFFFF,
    64'h4, 64'h100, 64'h0, 64'h7FFF_FFFF,
    64'h0, 64'h0
  };

  xbar_state_e seq_st [6] = '{IDLE, A_PHASE, D_WAIT, IDLE, A_PHASE, D_WAIT};

  initial begin
    logic [7:0] g;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.m_a_opcode = '0; bus.m_a_param = '0; bus.m_a_size = '0;
    bus.m_a_source = '0; bus.m_a_address = '0; bus.m_a_mask = '0;
    bus.m_a_data = '0; bus.m_a_corrupt = '0; bus.m_a_valid = '0;
    bus.m_d_ready = '0; bus.a_ready = 1'b0;
    bus.d_opcode = '0; bus.d_source = '0; bus.d_data = '0;
    bus.d_denied = 1'b0; bus.d_valid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    smp();
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("rst_avalid", 64'(bus.a_valid), 64'h0);
    check_eq("rst_sel", 64'(bus.chip_sel), 64'h0);
    check_eq("rst_caddr", bus.chip_addr, 64'h0);
    check_eq("rst_dready", 64'(bus.d_ready), 64'h0);
    check_eq("rst_addr", bus.a_address, 64'h0);
    cyc();
    rst_n = 1'b1;

    // M0 Get to RAM, response 3 cycles after the A handshake.
    bus.a_ready = 1'b1;
    bus.m_d_ready = 2'b11;
    cyc();
    set_req(0, OP_GET, 4'd3, 64'h8000_0010);
    smp();
    check_eq("t1_mready", 64'(bus.m_a_ready), 64'h1);
    check_eq("t1_avalid_req", 64'(bus.a_valid), 64'h0);
    cyc();
    clr_req(0);
    smp();
    check_eq("t1_avalid", 64'(bus.a_valid), 64'h1);
    check_eq("t1_sel", 64'(bus.chip_sel), 64'(6'b100000));
    check_eq("t1_caddr", bus.chip_addr, 64'h10);
    check_eq("t1_addr", bus.a_address, 64'h8000_0010);
    check_eq("t1_op", 64'(bus.a_opcode), 64'(OP_GET));
    check_eq("t1_src", 64'(bus.a_source), 64'h3);
    check_eq("t1_data", bus.a_data, 64'hcafe_0000_0000_0003);
    cyc();
    smp();
    check_eq("t1_dwait", 64'(dbg_state), 64'(D_WAIT));
    check_eq("t1_avalid_low", 64'(bus.a_valid), 64'h0);
    check_eq("t1_mdv_early", 64'(bus.m_d_valid), 64'h0);
    cyc();
    smp();
    check_eq("t1_mdv_early2", 64'(bus.m_d_valid), 64'h0);
    cyc();
    bus.d_valid = 1'b1; bus.d_opcode = OP_ACCESS_ACK_DATA;
    bus.d_source = 4'd3; bus.d_data = 64'hdead_beef_0000_0010;
    smp();
    check_eq("t1_mdv", 64'(bus.m_d_valid), 64'h1);
    check_eq("t1_ddata", bus.m_d_data, 64'hdead_beef_0000_0010);
    check_eq("t1_dop", 64'(bus.m_d_opcode), 64'(OP_ACCESS_ACK_DATA));
    check_eq("t1_dsrc", 64'(bus.m_d_source), 64'h3);
    check_eq("t1_dready", 64'(bus.d_ready), 64'h1);
    cyc();
    bus.d_valid = 1'b0;
    smp();
    check_eq("t1_done", 64'(dbg_state), 64'(IDLE));
    check_eq("t1_mdv_off", 64'(bus.m_d_valid), 64'h0);

    // M1 PutFull to an unmapped address: denied response, stray d_valid.
    cyc();
    bus.m_d_ready = 2'b00;
    bus.d_valid = 1'b1;
    set_req(1, 3'd0, 4'd9, 64'h4000_0000);
    smp();
    check_eq("t3_mready", 64'(bus.m_a_ready), 64'h2);
    check_eq("t3_dready_idle", 64'(bus.d_ready), 64'h0);
    cyc();
    clr_req(1);
    smp();
    check_eq("t3_avalid", 64'(bus.a_valid), 64'h0);
    check_eq("t3_sel", 64'(bus.chip_sel), 64'h0);
    check_eq("t3_mdv", 64'(bus.m_d_valid), 64'h2);
    check_eq("t3_denied", 64'(bus.m_d_denied), 64'h1);
    check_eq("t3_op", 64'(bus.m_d_opcode), 64'(OP_ACCESS_ACK));
    check_eq("t3_src", 64'(bus.m_d_source), 64'h9);
    check_eq("t3_data", bus.m_d_data, 64'h0);
    check_eq("t3_dready", 64'(bus.d_ready), 64'h0);
    cyc();
    smp();
    check_eq("t3_hold", 64'(bus.m_d_valid), 64'h2);
    check_eq("t3_avalid2", 64'(bus.a_valid), 64'h0);
    cyc();
    bus.m_d_ready = 2'b10;
    smp();
    check_eq("t3_hold2", 64'(bus.m_d_valid), 64'h2);
    cyc();
    bus.m_d_ready = 2'b11;
    bus.d_valid = 1'b0;
    smp();
    check_eq("t3_done", 64'(dbg_state), 64'(IDLE));
    check_eq("t3_mdv_off", 64'(bus.m_d_valid), 64'h0);

    // Decode boundaries, including region ends and the RAM top.
    bus.a_ready = 1'b1;
    bus.d_valid = 1'b1;
    bus.d_source = 4'd1;
    for (int i = 0; i < NPROBE; i++) probe(pv_addr[i], pv_sel[i], pv_off[i]);

    // Fresh reset, then both masters requesting: grants 0,1,0,1.
    cyc();
    rst_n = 1'b0;
    smp();
    check_eq("rr_rst", 64'(dbg_state), 64'(IDLE));
    cyc();
    rst_n = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        set_req(0, OP_GET, 4'd0, 64'h8000_0000);
        set_req(1, OP_GET, 4'd1, 64'h8000_1000);
      end
      smp();
      g = exp_q.pop_front();
      check_eq("rr_grant", 64'(bus.m_a_ready), 64'(2'b01 << g));
      cyc();
      smp();
      check_eq("rr_avalid", 64'(bus.a_valid), 64'h1);
      check_eq("rr_mready_off", 64'(bus.m_a_ready), 64'h0);
      check_eq("rr_src", 64'(bus.a_source), 64'(g));
      check_eq("rr_caddr", bus.chip_addr, (g == 8'd0) ? 64'h0 : 64'h1000);
      cyc();
      smp();
      check_eq("rr_mdv", 64'(bus.m_d_valid), 64'(2'b01 << g));
    end

    // Only M0 keeps requesting: back-to-back at one IDLE cycle each.
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 0) clr_req(1);
      smp();
      check_eq("b2b_state", 64'(dbg_state), 64'(seq_st[k]));
    end
    cyc();
    clr_req(0);
    bus.d_valid = 1'b0;
    smp();
    check_eq("b2b_idle", 64'(dbg_state), 64'(IDLE));

    // UART access stalled 5 cycles by a_ready; payload must stay put.
    bus.a_ready = 1'b0;
    cyc();
    set_req(0, OP_GET, 4'd5, 64'h1000_0005);
    smp();
    check_eq("t4_mready", 64'(bus.m_a_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) begin
        clr_req(0);
        bus.m_a_address[0] = 64'hdead_0000;
        bus.m_a_source[0] = 4'hf;
      end
      smp();
      check_eq("t4_avalid", 64'(bus.a_valid), 64'h1);
      check_eq("t4_addr", bus.a_address, 64'h1000_0005);
      check_eq("t4_caddr", bus.chip_addr, 64'h5);
      check_eq("t4_sel", 64'(bus.chip_sel), 64'(6'b001000));
      check_eq("t4_src", 64'(bus.a_source), 64'h5);
    end
    cyc();
    bus.a_ready = 1'b1;
    smp();
    check_eq("t4_avalid_hs", 64'(bus.a_valid), 64'h1);
    cyc();
    bus.a_ready = 1'b0;
    smp();
    check_eq("t4_dwait", 64'(dbg_state), 64'(D_WAIT));

    // Reset while waiting for D: everything drops at once.
    cyc();
    bus.d_valid = 1'b1;
    #1;
    check_eq("t5_pre_mdv", 64'(bus.m_d_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_state", 64'(dbg_state), 64'(IDLE));
    check_eq("t5_mdv", 64'(bus.m_d_valid), 64'h0);
    check_eq("t5_dready", 64'(bus.d_ready), 64'h0);
    check_eq("t5_avalid", 64'(bus.a_valid), 64'h0);
    check_eq("t5_mready", 64'(bus.m_a_ready), 64'h0);
    check_eq("t5_sel", 64'(bus.chip_sel), 64'h0);
    check_eq("t5_caddr", bus.chip_addr, 64'h0);
    check_eq("t5_addr", bus.a_address, 64'h0);
    bus.d_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    set_req(0, OP_GET, 4'd2, 64'h8000_0040);
    set_req(1, OP_GET, 4'd7, 64'h8000_0080);
    smp();
    check_eq("t5_first_grant", 64'(bus.m_a_ready), 64'h1);
    cyc();
    clr_req(0);
    clr_req(1);
    smp();
    check_eq("t5_src", 64'(bus.a_source), 64'h2);
    check_eq("t5_caddr2", bus.chip_addr, 64'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crossbar_arb.md
CROSSBAR_ARB -- requirements
Module: crossbar_arb

Interface
REQ-001 The block SHALL have parameter NM, default 2, meaning the number of A/D-channel masters.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have master A-channel ports m_a_opcode/param/size (in, NMx3), m_a_source (in, NMx4), m_a_address (in, NMx64), m_a_mask (in, NMx8), m_a_data (in, NMx64), m_a_corrupt (in, NM), m_a_valid (in, NM) and m_a_ready (out, NM).
REQ-005 The block SHALL have master D-channel ports m_d_opcode (out, 3), m_d_source (out, 4), m_d_data (out, 64), m_d_denied (out, 1), m_d_valid (out, NM) and m_d_ready (in, NM).
REQ-006 The block SHALL have slave A-channel ports a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt and a_valid (out, widths as in REQ-004) and a_ready (in, 1).
REQ-007 The block SHALL have decode outputs chip_sel (out, 6, one-hot) and chip_addr (out, 64, region offset).
REQ-008 The block SHALL have slave D-channel ports d_opcode (in, 3), d_source (in, 4), d_data (in, 64), d_denied (in, 1), d_valid (in, 1) and d_ready (out, 1).

Function
REQ-009 The FSM SHALL have states IDLE, A_PHASE, D_WAIT and ERR_RESP.
REQ-010 In IDLE with any m_a_valid set, the block SHALL grant round-robin starting from (last_grant+1) mod NM, register the grant index, the full A payload, chip_sel and chip_addr, and enter A_PHASE, or ERR_RESP if the address is unmapped.
REQ-011 The A beat of the granted master SHALL be accepted on the IDLE cycle (m_a_ready[g]=1 for exactly one cycle) so that the registered copy is forwarded.
REQ-012 In A_PHASE the block SHALL hold a_valid=1 with the registered payload stable; on a_valid&&a_ready it SHALL move to D_WAIT.
REQ-013 In D_WAIT the block SHALL drive m_d_valid[g]=d_valid, d_ready=m_d_ready[g] and pass the D fields through combinationally; on d_valid&&d_ready it SHALL return to IDLE and set last_grant=g.
REQ-014 Non-granted masters SHALL see m_a_ready=0 and m_d_valid=0 at all times; only one transaction SHALL be outstanding.
REQ-015 Decode SHALL use base <= addr < base+size (64-bit unsigned; no overflow for region 5) with chip_addr = addr - base, over: 0 ROM 0x1000/0x1000; 1 CLINT 0x0200_0000/0x1_0000; 2 PLIC 0x0C00_0000/0x0400_0000; 3 UART 0x1000_0000/0x100; 4 FLASH 0x2000_0000/0x0200_0000; 5 RAM 0x8000_0000/0x8000_0000.
REQ-016 For an unmapped address the block SHALL never assert a_valid, SHALL set chip_sel=0 and, in ERR_RESP, drive m_d_valid[g]=1 with m_d_denied=1, m_d_source equal to the captured source, m_d_data=0 and m_d_opcode=1 (AccessAckData) for Get (4), else 0 (AccessAck), returning to IDLE on m_d_ready[g].
REQ-017 A single requester SHALL be granted back-to-back, costing one IDLE cycle per transaction.
REQ-018 The latency from m_a_valid to a_valid SHALL be 1 cycle.
REQ-019 d_valid arriving outside D_WAIT SHALL be ignored (d_ready=0).

Reset
REQ-020 On rst_n low the block SHALL asynchronously enter IDLE with last_grant=NM-1, all valid/ready outputs 0, chip_sel=0, chip_addr=0 and the payload registers 0.
REQ-021 A reset in mid-transaction SHALL abandon it without any response; traffic after release SHALL start clean.

Structure
REQ-022 Package xbar_pkg SHALL hold the state enum, the region base/size constant arrays, CHIP_NUM=6 and the opcode constants (Get=4, AccessAck=0, AccessAckData=1).
REQ-023 Sub-module xbar_addr_decode SHALL be purely combinational, with address in and {hit, chip_sel, chip_addr} out.

Verification
REQ-024 The bench SHALL cover: M0 Get at 0x8000_0010, slave a_ready=1, d_valid after 3 cycles -> a_valid 1 cycle after request, chip_sel=6'b100000, chip_addr=0x10, m_d_valid[0] only.
REQ-025 The bench SHALL cover: M0 and M1 valid together, repeated 4 times -> grants alternate 0,1,0,1.
REQ-026 The bench SHALL cover: M1 PutFull at 0x4000_0000 -> no a_valid, m_d_valid[1]=1, denied=1, opcode=0, source echoed.
REQ-027 The bench SHALL cover: UART access at 0x1000_0005 with a_ready held low for 5 cycles -> payload and chip_addr=0x5 stable throughout, chip_sel=6'b001000.
REQ-028 The bench SHALL cover: rst_n dropped in D_WAIT -> all outputs 0 immediately; after release a fresh M0 request is granted first.
